mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//   Request sequencer placed directly upstream of the 64x8 data memory. Accepts byte read, write
//   and clear requests from the core over a valid/ready handshake. Holds address, mode and data
//   stable for the memory's multi-edge access windows: 2 edges for a read, 3 for a write.
//   Returns read data and write completion as a one-cycle response pulse.
// PARAMETERS
//   ADDR_W   6  byte address width (64 locations)
//   DATA_W   8  byte width
//   RD_EDGES 2  edges mem_adrs/mem_mode must be held for a read
//   WR_EDGES 3  edges mem_adrs/mem_mode/mem_data must be held for a write
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       core request present
//   req_ready  out  1       controller can accept; high only in IDLE
//   req_we     in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   DATA_W  write byte
//   clr_req    in   1       clear entire memory
//   rsp_valid  out  1       one-cycle pulse: request complete
//   rsp_rdata  out  DATA_W  read byte, valid with rsp_valid (reads only)
//   busy       out  1       high whenever state != IDLE
//   err        out  1       sticky write-verify mismatch flag (see CONFIGURATION)
//   mem_adrs   out  ADDR_W  to memory adrs
//   mem_mode   out  1       to memory mode (1 = write)
//   mem_data   out  DATA_W  to memory data
//   mem_erase  out  1       to memory erase
//   mem_out    in   DATA_W  from memory out
// BEHAVIOUR
//   Reset values: all outputs 0 except req_ready = 1. State = IDLE, edge counter = 0.
//   FSM states: IDLE, CLEAR, READ, WRITE, VERIFY (VERIFY exists only with the macro).
//   IDLE:
//     - mem_mode = 0 and mem_erase = 0, so the memory is never written while idle.
//     - mem_adrs/mem_data hold their last values.
//   Accept edge E0 (req_valid & req_ready): latch addr, wdata and we into mem_* registers.
//   READ:  mem_mode = 0 for edges E1..E2. mem_out is valid after E2.
//          At E3: rsp_rdata <= mem_out, rsp_valid <= 1, state -> IDLE.
//   WRITE: mem_mode = 1 for edges E1..E3. The memory location updates at E3.
//          At E3: rsp_valid <= 1, state -> IDLE. rsp_rdata holds its previous value.
//   Response: rsp_valid is high for exactly the one cycle after E3.
//             Next accept is possible at E4, giving a throughput of 1 request per 4 cycles.
//   CLEAR:
//     - clr_req sampled high in IDLE -> state CLEAR.
//     - mem_erase = 1 for exactly one edge, then state -> IDLE with a rsp_valid pulse.
//     - clr_req is ignored while not in IDLE.
//   Simultaneous clr_req & req_valid in IDLE:
//     - Clear wins. req_ready is forced 0 that cycle, so the request is not accepted.
//   mem_mode returns to 0 on the same edge the FSM leaves WRITE.
//   The edge counter is 2 bits and is compared against RD_EDGES-1 / WR_EDGES-1. It never wraps
//   within an access.
//   Reset mid-operation: abort immediately and emit no rsp_valid.
//     - Write aborted before E3: memory contents unchanged.
//     - Clear aborted: memory clears only if its erase edge occurred.
// CONFIGURATION
//   MEM_WRITE_VERIFY_EN defined:
//     - After WRITE's E3, enter VERIFY: mem_mode = 0, same address, edges E4..E5.
//     - At E6: compare mem_out with the latched wdata. On mismatch err <= 1 (sticky until rst_n).
//     - rsp_valid is pulsed at E6 instead of E3; rsp_rdata <= mem_out.
//   Not defined: no VERIFY state; write completes at E3; err is tied to 0.
// STRUCTURE
//   Package mem_pkg holds ADDR_W and DATA_W, RD_EDGES and WR_EDGES, and the FSM state encoding
//   (3-bit localparams).
//   No sub-module: the FSM and edge counter stay inline in mem_access_ctrl.
//   The bench pairs mem_access_ctrl with the existing data_mem instance.
// TESTING
//   1. Write 0xA5 @0x05, then read @0x05:
//      write rsp_valid 4 cycles after accept; read rsp_rdata = 0xA5, 4 cycles after accept.
//   2. Write 0x11,0x22,0x33,0x44 @0x04..0x07 (one 32-bit row), then read each address:
//      returns 0x11,0x22,0x33,0x44 with no lane corruption.
//   3. Write 0xFF @0x3F, clr_req, then read @0x3F:
//      returns 0x00. mem_erase is high for exactly 1 cycle.
//   4. clr_req and req_valid asserted in the same IDLE cycle:
//      req_ready = 0 that cycle, clear completes, then the request is accepted on the next cycle.
//   5. Read of 0x10 previously written 0x5A; drop rst_n one cycle after accept:
//      outputs reset, no rsp_valid, req_ready = 1. A later read of 0x10 returns 0x5A.
//   6. MEM_WRITE_VERIFY_EN with a stub forcing mem_out = 0x00; write 0x3C:
//      rsp_valid 7 cycles after accept, err = 1 and remains set.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared parameters and FSM encoding for the data-memory request sequencer.
// Optional feature macro: MEM_WRITE_VERIFY_EN (adds the VERIFY state).
package mem_pkg;

  localparam int ADDR_W   = 6;  // 64 byte locations
  localparam int DATA_W   = 8;  // byte-wide data
  localparam int RD_EDGES = 2;  // edges adrs/mode are held for a read
  localparam int WR_EDGES = 3;  // edges adrs/mode/data are held for a write
  localparam int CNT_W    = 2;  // edge counter width; max count within an access is 2

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
`ifdef MEM_WRITE_VERIFY_EN
  localparam logic [2:0] ST_VERIFY = 3'd4;
`endif

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    READ  = ST_READ,
    WRITE = ST_WRITE
`ifdef MEM_WRITE_VERIFY_EN
    , VERIFY = ST_VERIFY
`endif
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Request sequencer in front of the 64x8 data memory. Accepts read/write/clear
// requests over valid/ready, holds address/mode/data for the memory's access
// window and returns a one-cycle response pulse.
// Optional feature macro: MEM_WRITE_VERIFY_EN -- reads back every write and
// raises a sticky err flag on mismatch.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr_req,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic              mem_mode,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_erase,
  input  logic [DATA_W-1:0] mem_out
);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             accept, start_clr;
  logic             rd_done, wr_done;
`ifdef MEM_WRITE_VERIFY_EN
  logic             vf_done;
  logic             err_q;
`endif

  // Handshake and arbitration: a clear in IDLE wins and blocks acceptance that cycle.
  always_comb begin
    start_clr = (state == IDLE) && clr_req;
    req_ready = (state == IDLE) && !clr_req;
    accept    = req_ready && req_valid;
    busy      = (state != IDLE);
    // cnt counts edges since E1. A write ends on its last hold edge
    // (cnt == WR_EDGES-1); a read's last hold edge is cnt == RD_EDGES-1 and it
    // ends one capture edge later, once mem_out is valid.
    wr_done   = (cnt == CNT_W'(WR_EDGES - 1));
    rd_done   = (cnt == CNT_W'(RD_EDGES - 1) + CNT_W'(1));
`ifdef MEM_WRITE_VERIFY_EN
    vf_done   = rd_done;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred.
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_clr)   state_nx = CLEAR;
        else if (accept) state_nx = req_we ? WRITE : READ;
      end
      CLEAR: state_nx = IDLE;
      READ:  if (rd_done) state_nx = IDLE;
`ifdef MEM_WRITE_VERIFY_EN
      WRITE:  if (wr_done) state_nx = VERIFY;
      VERIFY: if (vf_done) state_nx = IDLE;
`else
      WRITE:  if (wr_done) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Edge counter: restarts on every state change, counts while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (state != IDLE)     cnt <= cnt + CNT_W'(1);
  end

  // Memory-side registers and response generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_adrs  <= '0;
      mem_data  <= '0;
      mem_mode  <= 1'b0;
      mem_erase <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_WRITE_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      mem_erase <= 1'b0;
      case (state)
        IDLE: begin
          if (start_clr) begin
            mem_erase <= 1'b1;
          end else if (accept) begin
            mem_adrs <= req_addr;
            mem_data <= req_wdata;
            mem_mode <= req_we;
          end
        end
        CLEAR: rsp_valid <= 1'b1;
        READ: begin
          if (rd_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_out;
          end
        end
        WRITE: begin
          if (wr_done) begin
            mem_mode <= 1'b0;
`ifndef MEM_WRITE_VERIFY_EN
            rsp_valid <= 1'b1;
`endif
          end
        end
`ifdef MEM_WRITE_VERIFY_EN
        VERIFY: begin
          if (vf_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_out;
            if (mem_out != mem_data) err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef MEM_WRITE_VERIFY_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
